// File: rtl/load_store_unit_if.sv
// Bundled pipeline-request, response and data-memory signals of the load/store unit.
// master = the LSU itself; slave = the pipeline and data memory facing it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        input  req_valid, is_load, is_store, size, sign_ext, addr, store_data, rdata,
        output req_ready, resp_valid, resp_err, load_data, MemRead, MemWrite, raddr, waddr, wdata
    );

    modport slave (
        output req_valid, is_load, is_store, size, sign_ext, addr, store_data, rdata,
        input  req_ready, resp_valid, resp_err, load_data, MemRead, MemWrite, raddr, waddr, wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: byte/half/word accesses to a word-addressed data memory,
// sub-word stores done as read-modify-write, all outputs registered.
module load_store_unit #(
    parameter int IDX_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.master   bus
);

    typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10, DONE = 2'b11} state_t;

    function automatic logic req_error(input logic ld, input logic st,
                                       input logic [1:0] sz, input logic [1:0] a);
        logic e;
        e = (ld == st) || (sz == 2'b11) ||
            ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
        return e;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (sz)
            2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic sx, input logic [1:0] lane);
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [1:0]         lane_r, lane_s;
    logic [31:0]        sdata_r, sdata_s;
    logic [1:0]         size_r, size_s;
    logic               sext_r, sext_s;
    logic               load_r, load_s;
    logic               err_r, err_s;
    logic [31:0]        buf_r, buf_s;

    logic               req_ready_r, req_ready_s;
    logic               resp_valid_r, resp_valid_s;
    logic               resp_err_r, resp_err_s;
    logic [31:0]        load_data_r, load_data_s;
    logic               mem_read_r, mem_read_s;
    logic               mem_write_r, mem_write_s;
    logic [31:0]        raddr_r, raddr_s;
    logic [31:0]        waddr_r, waddr_s;
    logic [31:0]        wdata_r, wdata_s;
    logic [31:0]        word_idx_s;

    // Next state, request capture, and next values of the registered outputs.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        lane_s  = lane_r;
        sdata_s = sdata_r;
        size_s  = size_r;
        sext_s  = sext_r;
        load_s  = load_r;
        err_s   = err_r;
        buf_s   = buf_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    idx_s   = bus.addr[IDX_W+1:2];
                    lane_s  = bus.addr[1:0];
                    sdata_s = bus.store_data;
                    size_s  = bus.size;
                    sext_s  = bus.sign_ext;
                    load_s  = bus.is_load;
                    err_s   = req_error(bus.is_load, bus.is_store, bus.size, bus.addr[1:0]);
                    if (err_s) begin
                        state_s = DONE;
                    end else if (bus.is_load || (bus.size != 2'b10)) begin
                        state_s = RD;
                    end else begin
                        state_s = WR;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                buf_s   = bus.rdata;
                state_s = load_r ? DONE : WR;
            end
            WR:      state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        word_idx_s = '0;
        word_idx_s[IDX_W-1:0] = idx_s;
        req_ready_s  = (state_s == IDLE);
        resp_valid_s = (state_s == DONE);
        resp_err_s   = (state_s == DONE) && err_s;
        mem_read_s   = (state_s == RD);
        mem_write_s  = (state_s == WR);
        raddr_s      = (state_s == RD) ? word_idx_s : 32'd0;
        waddr_s      = (state_s == WR) ? word_idx_s : 32'd0;
        wdata_s      = (state_s == WR) ? merge_store(buf_s, sdata_s, size_s, lane_s) : 32'd0;
        // Only a clean load returns data; stores and errors answer with zero.
        load_data_s  = ((state_s == DONE) && load_s && !err_s) ?
                       extract_load(buf_s, size_s, sext_s, lane_s) : 32'd0;
    end

    // State, captured request fields and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            lane_r       <= 2'b00;
            sdata_r      <= 32'd0;
            size_r       <= 2'b00;
            sext_r       <= 1'b0;
            load_r       <= 1'b0;
            err_r        <= 1'b0;
            buf_r        <= 32'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            load_data_r  <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            raddr_r      <= 32'd0;
            waddr_r      <= 32'd0;
            wdata_r      <= 32'd0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            lane_r       <= lane_s;
            sdata_r      <= sdata_s;
            size_r       <= size_s;
            sext_r       <= sext_s;
            load_r       <= load_s;
            err_r        <= err_s;
            buf_r        <= buf_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_err_r   <= resp_err_s;
            load_data_r  <= load_data_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            raddr_r      <= raddr_s;
            waddr_r      <= waddr_s;
            wdata_r      <= wdata_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.load_data  = load_data_r;
    assign bus.MemRead    = mem_read_r;
    assign bus.MemWrite   = mem_write_r;
    assign bus.raddr      = raddr_r;
    assign bus.waddr      = waddr_r;
    assign bus.wdata      = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 256-word behavioural data memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  load_store_unit_if bus ();

  load_store_unit #(.IDX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) if (bus.MemWrite) mem[bus.waddr[7:0]] <= bus.wdata;
  // Poison value outside MemRead exposes any sampling of rdata at the wrong time.
  assign bus.rdata = bus.MemRead ? mem[bus.raddr[7:0]] : 32'hDEAD_DEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ld, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d);
    bus.is_load    = ld;
    bus.is_store   = st;
    bus.size       = sz;
    bus.sign_ext   = sx;
    bus.addr       = a;
    bus.store_data = d;
  endtask

  // Present a request and return #1 after the accepting edge (start of cycle 1).
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    bit   done;
    done = 1'b0;
    set_req(ld, st, sz, sx, a, d);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      ok = bus.req_ready;
      step();
      if (ok) done = 1'b1;
    end
    bus.req_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] exp);
    issue(1'b1, 1'b0, sz, sx, a, 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check(tag, bus.load_data, exp);
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 1'b1, 2'b10, 1'b0, a, d);
    step();
    check("sw_done", 32'(bus.resp_valid), 32'd1);
  endtask

  task automatic expect_err(input string tag, input logic ld, input logic st,
                            input logic [1:0] sz, input logic [31:0] a);
    issue(ld, st, sz, 1'b1, a, 32'hFFFF_FFFF);
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_err"}, 32'(bus.resp_err), 32'd1);
    check({tag, "_mem"}, {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    check({tag, "_ldata"}, bus.load_data, 32'd0);
    step();
    check({tag, "_after"}, {29'd0, bus.resp_valid, bus.MemRead, bus.MemWrite}, 32'd0);
  endtask

  logic [31:0] b2b_exp [4];
  int acc;
  int nresp;
  logic ok;

  initial begin
    bus.req_valid = 1'b0;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Reset values.
    step(); step();
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_flags", {28'd0, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite}, 32'd0);
    check("rst_ldata", bus.load_data, 32'd0);
    check("rst_addr", bus.raddr | bus.waddr | bus.wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset while RD is active.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check("mid_rd_read", 32'(bus.MemRead), 32'd1);
    check("mid_rd_ready", 32'(bus.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_read", 32'(bus.MemRead), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_noresp", 32'(bus.resp_valid), 32'd0);
    step();
    check("post_rst_noresp2", 32'(bus.resp_valid), 32'd0);

    // Word path.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_write", 32'(bus.MemWrite), 32'd1);
    check("sw_waddr", bus.waddr, 32'd4);
    check("sw_wdata", bus.wdata, 32'hDEAD_BEEF);
    check("sw_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("sw_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd2);
    check("sw_ldata", bus.load_data, 32'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check("lw_read", 32'(bus.MemRead), 32'd1);
    check("lw_raddr", bus.raddr, 32'd4);
    step();
    check("lw_valid", 32'(bus.resp_valid), 32'd1);
    check("lw_data", bus.load_data, 32'hDEAD_BEEF);

    // Sub-word stores (read-modify-write).
    do_sw(32'h10, 32'h1122_3344);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    check("sb_read", 32'(bus.MemRead), 32'd1);
    step();
    check("sb_write", 32'(bus.MemWrite), 32'd1);
    check("sb_wdata", bus.wdata, 32'h11AA_3344);
    step();
    check("sb_valid", 32'(bus.resp_valid), 32'd1);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
    check("sh_cyc1_noresp", 32'(bus.resp_valid), 32'd0);
    step();
    check("sh_wdata", bus.wdata, 32'hBEEF_3344);
    check("sh_cyc2_noresp", 32'(bus.resp_valid), 32'd0);
    step();
    check("sh_valid", 32'(bus.resp_valid), 32'd1);
    do_load("lw_after_sh", 2'b10, 1'b0, 32'h10, 32'hBEEF_3344);

    // Extended loads.
    do_sw(32'h10, 32'h80FF_7F01);
    do_load("lb", 2'b00, 1'b1, 32'h12, 32'hFFFF_FFFF);
    do_load("lbu", 2'b00, 1'b0, 32'h12, 32'h0000_00FF);
    do_load("lh", 2'b01, 1'b1, 32'h12, 32'hFFFF_80FF);
    do_load("lhu", 2'b01, 1'b0, 32'h10, 32'h0000_7F01);
    do_load("lb0", 2'b00, 1'b1, 32'h10, 32'h0000_0001);

    // Errors.
    expect_err("err_lh_odd", 1'b1, 1'b0, 2'b01, 32'h11);
    expect_err("err_sw_mis", 1'b0, 1'b1, 2'b10, 32'h12);
    expect_err("err_size3", 1'b1, 1'b0, 2'b11, 32'h10);
    expect_err("err_both", 1'b1, 1'b1, 2'b10, 32'h10);
    do_load("lw_after_err", 2'b10, 1'b0, 32'h10, 32'h80FF_7F01);

    // Back-to-back with req_valid held high.
    b2b_exp[0] = 32'd0;
    b2b_exp[1] = 32'd0;
    b2b_exp[2] = 32'hA5A5_55A5;
    b2b_exp[3] = 32'h0000_A5A5;
    acc = 0;
    nresp = 0;
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 60 && nresp < 4; c++) begin
      @(negedge clk);
      ok = bus.req_ready && bus.req_valid;
      step();
      if (ok) begin
        acc++;
        case (acc)
          1: set_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055);
          2: set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
          3: set_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
          default: bus.req_valid = 1'b0;
        endcase
      end
      if (bus.MemRead || bus.MemWrite || bus.resp_valid)
        check("b2b_stall", 32'(bus.req_ready), 32'd0);
      if (bus.resp_valid) begin
        check("b2b_err", 32'(bus.resp_err), 32'd0);
        check("b2b_data", bus.load_data, b2b_exp[nresp]);
        nresp++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd4);
    check("b2b_resps", 32'(nresp), 32'd4);

    // Address wrap.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h1234_5678);
    check("wrap_waddr", bus.waddr, 32'd0);
    step();
    step();
    do_load("wrap_lw", 2'b10, 1'b0, 32'h0, 32'h1234_5678);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: MEM-stage load/store engine for the MIPS32 core.
- Accepts one load or store per handshake from the pipeline and drives MemRead/MemWrite/raddr/waddr/wdata toward the word-addressed data memory.
- Supports byte, halfword and word accesses (lb/lbu/lh/lhu/lw/sb/sh/sw) with little-endian lane selection, sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned or illegal requests; stalls the pipeline via req_ready.

Parameters:
- IDX_W, 8, word-index width driven onto raddr/waddr low bits (memory depth 2^IDX_W words).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  pipeline presents a request
- req_ready  output  1  LSU idle and able to accept; pipeline stalls while low
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
- addr  input  32  byte address
- store_data  input  32  store operand; byte/half in low bits
- resp_valid  output  1  one-cycle pulse: request complete
- resp_err  output  1  valid with resp_valid: misaligned or illegal request
- load_data  output  32  valid with resp_valid for loads; 0 otherwise
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable (memory writes on posedge clk)
- raddr  output  32  read word index: {zeros, addr[IDX_W+1:2]}
- waddr  output  32  write word index, same mapping
- wdata  output  32  write data
- rdata  input  32  memory read data; combinational, valid only while MemRead=1 (Z otherwise)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all request registers cleared.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, load_data=0, MemRead=0, MemWrite=0, raddr=0, waddr=0, wdata=0.
- All memory-side outputs are decoded from state and registered request fields, never from live inputs.
- States: IDLE, RD, WR, DONE.
- IDLE: req_ready=1. On req_valid=1, register addr, store_data, size, sign_ext and the op.
  - Error if any holds: is_load==is_store; size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0. Error goes to DONE with resp_err=1 and no memory access.
  - Load goes to RD. Word store goes to WR. Byte or half store goes to RD.
- RD: MemRead=1, raddr=word index. rdata is sampled into a 32-bit word buffer at the rising edge ending the cycle.
  - Load: go to DONE.
  - Sub-word store: go to WR.
- WR: MemWrite=1, waddr=word index.
  - Word store: wdata = store_data.
  - Byte store: wdata = buffer with lane addr[1:0] (bits 8*lane+7:8*lane) replaced by store_data[7:0].
  - Half store: wdata = buffer with half addr[1] replaced by store_data[15:0].
  - Go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RD/WR/DONE.
  - load_data for a load: byte = buffer[8*lane+7:8*lane]; half = buffer[16*addr[1]+15:16*addr[1]]; extended per sign_ext; word = buffer.
  - load_data is 0 for stores and errors.
- Latency, counted from the acceptance cycle (cycle 0):
  - load: resp_valid in cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
  - error: cycle 1
  - Next acceptance is possible in the cycle after DONE.
- No backpressure on the response; the pipeline must consume it in the DONE cycle.
- Inputs are ignored while req_ready=0.
- Reset mid-operation: MemWrite/MemRead drop immediately. A WR state aborted before its clock edge performs no write. No resp_valid follows reset.
- Address bits above IDX_W+1 are ignored (wrap modulo memory size).

Test Plan:
- Reset and word path: assert rst_n=0 mid-RD -> MemRead=0 and req_ready=1 immediately. Then sw 0xDEADBEEF @0x10 followed by lw @0x10 -> MemWrite with waddr=4 in cycle 1, load_data=0xDEADBEEF with resp_valid in cycle 2.
- Sub-word stores: preload word 4=0x11223344; sb 0xAA @0x12 -> RD then WR with wdata=0x11AA3344. sh 0xBEEF @0x12 -> wdata=0xBEEF3344, resp_valid in cycle 3.
- Extended loads: word 4=0x80FF7F01.
  - lb @0x12 -> 0xFFFFFFFF
  - lbu @0x12 -> 0x000000FF
  - lh @0x12 -> 0xFFFF80FF
  - lhu @0x10 -> 0x00007F01
- Errors: lh @0x11, sw @0x12, size=11, is_load=is_store=1 -> each gives resp_err=1 in cycle 1, MemRead=MemWrite=0 throughout, load_data=0.
- Back-to-back with stall: hold req_valid=1 with 4 queued requests -> req_ready low during RD/WR/DONE, each request accepted exactly once, responses in order.
- Wrap: sw 0x12345678 @0x400 then lw @0x0 -> 0x12345678.
